// File: rtl/sync_fifo_wm.sv
// rtl/sync_fifo_wm.sv - single-clock show-ahead FIFO with watermarks, flush and sticky error flags.
// Optional SYNC_FIFO_WM_FALL_THROUGH_EN: while empty, data_o follows data_i and push+pop passes through.
module sync_fifo_wm #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int ALMOST_FULL_THR  = 6,
  parameter int ALMOST_EMPTY_THR = 1,
  localparam int LOG_BUFFER_DEPTH = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      full_o,
  output logic                      almost_full_o,
  input  logic                      pop_i,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      empty_o,
  output logic                      almost_empty_o,
  output logic [LOG_BUFFER_DEPTH:0] count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int CW = LOG_BUFFER_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THR);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THR);
  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_C = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic                        r_overflow;
  logic                        r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pass;
  logic w_push_acc;
  logic w_pop_acc;

  function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_next(input logic [LOG_BUFFER_DEPTH-1:0] p);
    return (p == LAST_C) ? '0 : p + LOG_BUFFER_DEPTH'(1);
  endfunction

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

`ifdef SYNC_FIFO_WM_FALL_THROUGH_EN
  // The word bypasses storage entirely, so pointers and count stay put.
  assign w_pass = push_i & pop_i & w_empty;
`else
  assign w_pass = 1'b0;
`endif

  assign w_push_acc = push_i & ~w_full & ~w_pass & ~flush_i;
  assign w_pop_acc  = pop_i & ~w_empty & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_acc && w_pop_acc) begin
        r_count <= r_count - CW'(1);
      end
      if (push_i && w_full) begin
        r_overflow <= 1'b1;
      end
      if (pop_i && w_empty && !w_pass) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= AF_C);
  assign almost_empty_o = (r_count <= AE_C);
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

`ifdef SYNC_FIFO_WM_FALL_THROUGH_EN
  assign data_o = w_empty ? data_i : r_mem[r_rd_ptr];
`else
  assign data_o = r_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_sync_fifo_wm.sv
// tb/tb_sync_fifo_wm.sv - table vectors, corner sequences and random run against a queue model.
module tb_sync_fifo_wm;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, afull, empty, aempty, ovf, udf;
  logic [3:0]    count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_wm #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ALMOST_FULL_THR(AF), .ALMOST_EMPTY_THR(AE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .data_i(din),
    .full_o(full), .almost_full_o(afull), .pop_i(pop), .data_o(dout),
    .empty_o(empty), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(udf)
  );

  typedef struct {
    bit          f, p, o;
    logic [31:0] d;
    int          cnt;
    logic [31:0] head;
    bit          eo, eu;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit f, input bit p, input bit o, input logic [31:0] d);
    flush = f; push = p; pop = o; din = d;
  endtask

  task automatic model_step(input bit f, input bit p, input bit o, input logic [31:0] d);
    bit was_full, was_empty, pass;
    if (f) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
`ifdef SYNC_FIFO_WM_FALL_THROUGH_EN
      pass = p && o && was_empty;
`else
      pass = 1'b0;
`endif
      if (!pass) begin
        if (p && was_full) m_ovf = 1;
        if (o && was_empty) m_udf = 1;
        if (o && !was_empty) void'(q.pop_front());
        if (p && !was_full) q.push_back(d);
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".afull"}, 32'(afull), 32'(n >= AF));
    chk({tag, ".aempty"}, 32'(aempty), 32'(n <= AE));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
    if (n > 0) chk({tag, ".data"}, dout, q[0]);
  endtask

  task automatic cyc(input string tag, input bit f, input bit p, input bit o, input logic [31:0] d);
    drive(f, p, o, d);
    model_step(f, p, o, d);
    tick();
    compare_model(tag);
  endtask

  task automatic add_vec(input bit f, input bit p, input bit o, input logic [31:0] d,
                         input int cnt, input logic [31:0] head, input bit eo, input bit eu);
    vec_t v;
    v.f = f; v.p = p; v.o = o; v.d = d; v.cnt = cnt; v.head = head; v.eo = eo; v.eu = eu;
    tbl.push_back(v);
  endtask

  logic [31:0] popped[$];
  logic [31:0] exp_seq[$];

  initial begin
    // Vector table: fill, overflow, push+pop at full and at count 4, flush, underflow.
    add_vec(0, 1, 0, 32'hA5, 1, 32'hA5, 0, 0);
    add_vec(0, 0, 1, 32'h0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 8; k++) add_vec(0, 1, 0, 32'(k), k + 1, 32'h0, 0, 0);
    add_vec(0, 1, 0, 32'hFF, 8, 32'h0, 1, 0);
    add_vec(0, 1, 1, 32'hEE, 7, 32'h1, 1, 0);
    add_vec(0, 0, 1, 32'h0, 6, 32'h2, 1, 0);
    add_vec(0, 0, 1, 32'h0, 5, 32'h3, 1, 0);
    add_vec(1, 1, 1, 32'h77, 0, 32'h0, 0, 0);
    add_vec(0, 0, 1, 32'h0, 0, 32'h0, 0, 1);
    add_vec(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 4; k++) add_vec(0, 1, 0, 32'h20 + 32'(k), k + 1, 32'h20, 0, 0);
    add_vec(0, 1, 1, 32'h24, 4, 32'h21, 0, 0);
    add_vec(0, 1, 1, 32'h25, 4, 32'h22, 0, 0);
    add_vec(0, 0, 1, 32'h0, 3, 32'h23, 0, 0);
    add_vec(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);

    // Reset state, then release.
    tick();
    chk("rst.empty", 32'(empty), 1);
    chk("rst.aempty", 32'(aempty), 1);
    chk("rst.count", 32'(count), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.afull", 32'(afull), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.udf", 32'(udf), 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].f, tbl[i].p, tbl[i].o, tbl[i].d);
      tick();
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
      chk($sformatf("vec%0d.afull", i), 32'(afull), 32'(tbl[i].cnt >= AF));
      chk($sformatf("vec%0d.aempty", i), 32'(aempty), 32'(tbl[i].cnt <= AE));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(tbl[i].eo));
      chk($sformatf("vec%0d.udf", i), 32'(udf), 32'(tbl[i].eu));
      if (tbl[i].cnt > 0) chk($sformatf("vec%0d.data", i), dout, tbl[i].head);
    end
    drive(0, 0, 0, 0);
    q.delete(); m_ovf = 0; m_udf = 0;

    // Fill then drain across the wrap with interleaved pushes.
    for (int k = 0; k < 8; k++) cyc("fill", 0, 1, 0, 32'(k));
    for (int k = 0; k < 12; k++) begin
      if (!empty) popped.push_back(dout);
      cyc("drain", 0, (k >= 1 && k <= 4), 1, 32'h10 + 32'(k - 1));
    end
    for (int k = 0; k < 8; k++) exp_seq.push_back(32'(k));
    for (int k = 0; k < 4; k++) exp_seq.push_back(32'h10 + 32'(k));
    chk("drain.len", 32'(popped.size()), 32'(exp_seq.size()));
    foreach (exp_seq[i]) if (i < popped.size()) chk($sformatf("drain.word%0d", i), popped[i], exp_seq[i]);
    cyc("udf", 0, 0, 1, 0);
    chk("udf.flag", 32'(udf), 1);
    cyc("clr", 1, 0, 0, 0);

    // Push and pop together on an empty FIFO.
    drive(0, 1, 1, 32'h3C);
    #1;
`ifdef SYNC_FIFO_WM_FALL_THROUGH_EN
    chk("ft.comb_data", dout, 32'h3C);
`endif
    model_step(0, 1, 1, 32'h3C);
    tick();
    compare_model("ft");
`ifdef SYNC_FIFO_WM_FALL_THROUGH_EN
    chk("ft.count", 32'(count), 0);
    chk("ft.udf", 32'(udf), 0);
`else
    chk("ft.count", 32'(count), 1);
    chk("ft.udf", 32'(udf), 1);
`endif
    cyc("clr2", 1, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle with content and overflow.
    for (int k = 0; k < 9; k++) cyc("prerst", 0, 1, 0, 32'hB0 + 32'(k));
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.ovf", 32'(ovf), 0);
    q.delete(); m_ovf = 0; m_udf = 0;
    tick();
    rst = 1'b0;
    cyc("postrst", 0, 1, 0, 32'hA5);
    chk("postrst.data", dout, 32'hA5);

    // Random traffic with shifting push/pop bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      cyc("rnd",
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5))),
          ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5))),
          $urandom());
    end
    drive(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
